// File: rtl/bf16_norm_pkg.sv
// Shared types and constants for the BFloat16 normalisation arbiter.
package bf16_norm_pkg;

  localparam int unsigned M_W   = 16;
  localparam int unsigned E_W   = 8;
  localparam int unsigned CNT_W = $clog2(M_W + 1);

  typedef struct packed {
    logic             sign;
    logic [E_W-1:0]   exp;
    logic [M_W-1:0]   man;
  } norm_req_t;

  typedef struct packed {
    norm_req_t        val;
    logic             uflow;
    logic             id;
  } norm_res_t;

  // Two-way round-robin pick: a lone requester always wins; on a tie the
  // requester that was not granted last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last_id);
    logic [1:0] g;
    g = '0;
    unique case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last_id ? 2'b01 : 2'b10;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bf16_norm_arbiter_lzc.sv
// Tree leading-zero counter. Result is W when the input is all zero.
module lzc #(
  parameter  int unsigned W     = 16,
  localparam int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     d_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Heap-ordered binary tree: node n has children 2n and 2n+1, leaves at
  // W..2W-1 with leaf W holding the MSB. A node's count is its left child's
  // count, or the left child's size plus the right child's count when the
  // left half is entirely zero.
  function automatic logic [CNT_W-1:0] lzc_tree(input logic [W-1:0] d);
    logic             z  [2*W];
    logic [CNT_W-1:0] c  [2*W];
    logic [CNT_W-1:0] sz [2*W];
    z[0]  = 1'b0;
    c[0]  = '0;
    sz[0] = '0;
    for (int unsigned j = 0; j < W; j++) begin
      z[W+j]  = ~d[W-1-j];
      c[W+j]  = z[W+j] ? CNT_W'(1) : '0;
      sz[W+j] = CNT_W'(1);
    end
    for (int unsigned n = W - 1; n >= 1; n--) begin
      z[n]  = z[2*n] & z[2*n+1];
      c[n]  = z[2*n] ? (sz[2*n] + c[2*n+1]) : c[2*n];
      sz[n] = sz[2*n] + sz[2*n+1];
    end
    return c[1];
  endfunction

  // Count is purely combinational on the input vector.
  always_comb begin
    cnt_o = lzc_tree(d_i);
  end

endmodule

// File: rtl/bf16_norm_arbiter.sv
// Shared normalisation unit: round-robin arbiter between adder (0) and
// multiplier (1), LZC in S1, left shift and exponent adjust in S2.
module bf16_norm_arbiter #(
  parameter int unsigned M_W = bf16_norm_pkg::M_W,
  parameter int unsigned E_W = bf16_norm_pkg::E_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0]       req_sign_i,
  input  logic [2*E_W-1:0] req_exp_i,
  input  logic [2*M_W-1:0] req_man_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_id_o,
  output logic             out_sign_o,
  output logic [E_W-1:0]   out_exp_o,
  output logic [M_W-1:0]   out_man_o,
  output logic             out_uflow_o
);

  import bf16_norm_pkg::*;

  localparam int unsigned CNT_W = $clog2(M_W + 1);
  localparam int unsigned CMP_W = (E_W > CNT_W) ? E_W : CNT_W;

  logic             adv1, adv2, hs;
  logic [1:0]       grant;
  logic             gnt_id;
  logic             mux_sign;
  logic [E_W-1:0]   mux_exp;
  logic [M_W-1:0]   mux_man;
  logic [CNT_W-1:0] mux_cnt;

  logic             last_q, last_d;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_id_q,    s1_id_d;
  logic             s1_sign_q,  s1_sign_d;
  logic [E_W-1:0]   s1_exp_q,   s1_exp_d;
  logic [M_W-1:0]   s1_man_q,   s1_man_d;
  logic [CNT_W-1:0] s1_cnt_q,   s1_cnt_d;

  logic             out_valid_q, out_valid_d;
  logic             out_id_q,    out_id_d;
  logic             out_sign_q,  out_sign_d;
  logic [E_W-1:0]   out_exp_q,   out_exp_d;
  logic [M_W-1:0]   out_man_q,   out_man_d;
  logic             out_uflow_q, out_uflow_d;

  assign adv2 = ~out_valid_q | out_ready_i;
  assign adv1 = ~s1_valid_q | adv2;

  // Grant, ready and the input mux feeding the single LZC.
  always_comb begin
    grant       = rr_pick(req_valid_i, last_q);
    req_ready_o = (adv1 && !reset) ? grant : '0;
    hs          = |req_ready_o;
    gnt_id      = grant[1];
    mux_sign    = req_sign_i[gnt_id];
    mux_exp     = req_exp_i[gnt_id*E_W +: E_W];
    mux_man     = req_man_i[gnt_id*M_W +: M_W];
  end

  lzc #(
    .W (M_W)
  ) u_lzc (
    .d_i   (mux_man),
    .cnt_o (mux_cnt)
  );

  // S1 next state: capture on handshake, drain to empty when advancing idle.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_man_d   = s1_man_q;
    s1_cnt_d   = s1_cnt_q;
    last_d     = last_q;
    if (adv1) begin
      s1_valid_d = hs;
      if (hs) begin
        s1_id_d   = gnt_id;
        s1_sign_d = mux_sign;
        s1_exp_d  = mux_exp;
        s1_man_d  = mux_man;
        s1_cnt_d  = mux_cnt;
        last_d    = gnt_id;
      end
    end
  end

  // S1 and round-robin pointer registers; pointer resets to 1 so 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
      s1_cnt_q   <= '0;
      last_q     <= 1'b1;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_man_q   <= s1_man_d;
      s1_cnt_q   <= s1_cnt_d;
      last_q     <= last_d;
    end
  end

  // S2 next state: zero / underflow flush / shift-and-adjust; hold otherwise.
  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_man_d   = out_man_q;
    out_uflow_d = out_uflow_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_id_d   = s1_id_q;
        out_sign_d = s1_sign_q;
        if (s1_cnt_q == CNT_W'(M_W)) begin
          out_exp_d   = '0;
          out_man_d   = '0;
          out_uflow_d = 1'b0;
        end else if (CMP_W'(s1_exp_q) <= CMP_W'(s1_cnt_q)) begin
          out_exp_d   = '0;
          out_man_d   = '0;
          out_uflow_d = 1'b1;
        end else begin
          out_exp_d   = s1_exp_q - E_W'(s1_cnt_q);
          out_man_d   = s1_man_q << s1_cnt_q;
          out_uflow_d = 1'b0;
        end
      end
    end
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_man_q   <= '0;
      out_uflow_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_man_q   <= out_man_d;
      out_uflow_q <= out_uflow_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_id_o    = out_id_q;
  assign out_sign_o  = out_sign_q;
  assign out_exp_o   = out_exp_q;
  assign out_man_o   = out_man_q;
  assign out_uflow_o = out_uflow_q;

endmodule
